// File: rtl/axi_lite_regtest_master_if.sv
// AXI4-Lite bus bundle used by axi_lite_regtest_master.
// master modport: drives AW/W/AR channels and BREADY/RREADY,
//                 observes the ready signals and the B/R responses.
// slave modport : the mirror image, for a memory or register target.
interface axi_lite_regtest_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR;
  logic                    M_AXI_AWVALID;
  logic                    M_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   M_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB;
  logic                    M_AXI_WVALID;
  logic                    M_AXI_WREADY;
  logic [1:0]              M_AXI_BRESP;
  logic                    M_AXI_BVALID;
  logic                    M_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR;
  logic                    M_AXI_ARVALID;
  logic                    M_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]   M_AXI_RDATA;
  logic [1:0]              M_AXI_RRESP;
  logic                    M_AXI_RVALID;
  logic                    M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
           M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
           M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
           M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
           M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );
endinterface

// File: rtl/axi_lite_regtest_master.sv
// AXI4-Lite register write/read-back tester.
// Each run writes NUM_REGS registers (data = seed rotated left by the
// register index, address = BASE_ADDR + index * DATA_WIDTH/8), reads each
// one back right after writing it and counts the registers that fail.
// Ports:
//   ACLK, ARESETN       clock, synchronous active-low reset
//   start, seed         run launch pulse and pattern seed
//   done, pass          run finished / finished cleanly
//   err_count           saturating count of failed registers
//   resp_err            sticky: some BRESP/RRESP was not OKAY
//   timeout             (REGTEST_TIMEOUT_EN only) sticky handshake timeout
//   m_axi               AXI4-Lite master bus
// Optional feature macro: REGTEST_TIMEOUT_EN -- a 1024-cycle handshake
// watchdog that forces the run to DONE with pass low.
module axi_lite_regtest_master #(
  parameter int                     DATA_WIDTH = 32,
  parameter int                     ADDR_WIDTH = 32,
  parameter int                     NUM_REGS   = 4,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  done,
  output logic                  pass,
  output logic [8:0]            err_count,
  output logic                  resp_err,
`ifdef REGTEST_TIMEOUT_EN
  output logic                  timeout,
`endif
  axi_lite_regtest_master_if.master m_axi
);

  localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [8:0]            LAST_IDX = 9'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WRESP, S_READ, S_RDATA, S_DONE
  } state_t;

  function automatic logic [DATA_WIDTH-1:0] rotl1(input logic [DATA_WIDTH-1:0] v);
    return {v[DATA_WIDTH-2:0], v[DATA_WIDTH-1]};
  endfunction

  function automatic logic [8:0] sat_inc(input logic [8:0] v);
    return (v == 9'h1FF) ? v : v + 9'd1;
  endfunction

  // Anything but OKAY (including EXOKAY, which AXI4-Lite never permits).
  function automatic logic resp_bad(input logic [1:0] resp);
    return resp != 2'b00;
  endfunction

  state_t                r_state;
  logic [8:0]            r_idx;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_pattern;
  logic                  r_aw_done, r_w_done, r_reg_fail;
  logic                  r_done, r_resp_err;
  logic [8:0]            r_err_count;
  logic [ADDR_WIDTH-1:0] r_awaddr, r_araddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;

  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_aw_ok, w_w_ok, w_rd_bad, w_last;

  assign w_aw_hs  = r_awvalid & m_axi.M_AXI_AWREADY;
  assign w_w_hs   = r_wvalid  & m_axi.M_AXI_WREADY;
  assign w_b_hs   = r_bready  & m_axi.M_AXI_BVALID;
  assign w_ar_hs  = r_arvalid & m_axi.M_AXI_ARREADY;
  assign w_r_hs   = r_rready  & m_axi.M_AXI_RVALID;
  // A channel counts as finished if it completed earlier or completes now.
  assign w_aw_ok  = r_aw_done | w_aw_hs;
  assign w_w_ok   = r_w_done  | w_w_hs;
  assign w_rd_bad = (m_axi.M_AXI_RDATA != r_pattern) | resp_bad(m_axi.M_AXI_RRESP);
  assign w_last   = (r_idx == LAST_IDX);

`ifdef REGTEST_TIMEOUT_EN
  logic [9:0] r_wait_cnt;
  logic       r_timeout;
  logic       w_waiting, w_any_hs;
  assign w_waiting = (r_state == S_WRITE) | (r_state == S_WRESP) |
                     (r_state == S_READ)  | (r_state == S_RDATA);
  assign w_any_hs  = w_aw_hs | w_w_hs | w_b_hs | w_ar_hs | w_r_hs;
  assign timeout   = r_timeout;
  assign pass      = r_done & (r_err_count == 9'd0) & ~r_resp_err & ~r_timeout;
`else
  assign pass      = r_done & (r_err_count == 9'd0) & ~r_resp_err;
`endif

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_addr      <= '0;
      r_pattern   <= '0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_reg_fail  <= 1'b0;
      r_done      <= 1'b0;
      r_resp_err  <= 1'b0;
      r_err_count <= '0;
      r_awaddr    <= '0;
      r_araddr    <= '0;
      r_wdata     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
`ifdef REGTEST_TIMEOUT_EN
      r_wait_cnt  <= '0;
      r_timeout   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state     <= S_WRITE;
            r_done      <= 1'b0;
            r_err_count <= '0;
            r_resp_err  <= 1'b0;
            r_reg_fail  <= 1'b0;
            r_idx       <= '0;
            r_addr      <= BASE_ADDR;
            r_awaddr    <= BASE_ADDR;
            r_pattern   <= seed;
            r_wdata     <= seed;
            r_awvalid   <= 1'b1;
            r_wvalid    <= 1'b1;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
`ifdef REGTEST_TIMEOUT_EN
            r_timeout   <= 1'b0;
`endif
          end
        end
        S_WRITE: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_ok && w_w_ok) begin
            r_state   <= S_WRESP;
            r_bready  <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end
        end
        S_WRESP: begin
          if (w_b_hs) begin
            r_bready <= 1'b0;
            if (resp_bad(m_axi.M_AXI_BRESP)) begin
              r_reg_fail <= 1'b1;
              r_resp_err <= 1'b1;
            end
            r_state   <= S_READ;
            r_araddr  <= r_addr;
            r_arvalid <= 1'b1;
          end
        end
        S_READ: begin
          if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (w_r_hs) begin
            r_rready <= 1'b0;
            if (resp_bad(m_axi.M_AXI_RRESP)) r_resp_err <= 1'b1;
            // One increment per register, whichever checks failed.
            if (r_reg_fail || w_rd_bad) r_err_count <= sat_inc(r_err_count);
            r_reg_fail <= 1'b0;
            if (w_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state   <= S_WRITE;
              r_idx     <= r_idx + 9'd1;
              r_addr    <= r_addr + STRIDE;
              r_awaddr  <= r_addr + STRIDE;
              r_pattern <= rotl1(r_pattern);
              r_wdata   <= rotl1(r_pattern);
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
`ifdef REGTEST_TIMEOUT_EN
      // Watchdog overrides the state update above: it only fires in a
      // cycle with no handshake, where the case arms merely hold.
      if (w_waiting && !w_any_hs) begin
        if (r_wait_cnt == 10'h3FF) begin
          r_state    <= S_DONE;
          r_done     <= 1'b1;
          r_timeout  <= 1'b1;
          r_awvalid  <= 1'b0;
          r_wvalid   <= 1'b0;
          r_bready   <= 1'b0;
          r_arvalid  <= 1'b0;
          r_rready   <= 1'b0;
          r_aw_done  <= 1'b0;
          r_w_done   <= 1'b0;
          r_wait_cnt <= '0;
        end else begin
          r_wait_cnt <= r_wait_cnt + 10'd1;
        end
      end else begin
        r_wait_cnt <= '0;
      end
`endif
    end
  end

  assign done                = r_done;
  assign err_count           = r_err_count;
  assign resp_err            = r_resp_err;
  assign m_axi.M_AXI_AWADDR  = r_awaddr;
  assign m_axi.M_AXI_AWVALID = r_awvalid;
  assign m_axi.M_AXI_WDATA   = r_wdata;
  assign m_axi.M_AXI_WSTRB   = '1;
  assign m_axi.M_AXI_WVALID  = r_wvalid;
  assign m_axi.M_AXI_BREADY  = r_bready;
  assign m_axi.M_AXI_ARADDR  = r_araddr;
  assign m_axi.M_AXI_ARVALID = r_arvalid;
  assign m_axi.M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_axi_lite_regtest_master.sv
// Directed bench for axi_lite_regtest_master with a configurable memory slave.
module tb_axi_lite_regtest_master;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        start = 1'b0;
  logic [31:0] seed = '0;
  logic        done, pass, resp_err;
  logic [8:0]  err_count;
`ifdef REGTEST_TIMEOUT_EN
  logic        timeout;
`endif

  always #5 ACLK = ~ACLK;

  axi_lite_regtest_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) axi ();

  axi_lite_regtest_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(4), .BASE_ADDR(32'h0)) dut (
    .ACLK(ACLK),
    .ARESETN(ARESETN),
    .start(start),
    .seed(seed),
    .done(done),
    .pass(pass),
    .err_count(err_count),
    .resp_err(resp_err),
`ifdef REGTEST_TIMEOUT_EN
    .timeout(timeout),
`endif
    .m_axi(axi)
  );

  // ---------------- memory slave ----------------
  int aw_delay = 0, w_delay = 0, ar_delay = 0;
  int flip_idx = -1, slverr_idx = -1;
  int aw_cnt, w_cnt, ar_cnt;
  logic        aw_got, w_got, s_bvalid, s_rvalid;
  logic [1:0]  s_bresp;
  logic [31:0] aw_addr_q, w_data_q, s_rdata;
  logic [31:0] mem [16];
  logic [31:0] wr_a, wr_d;
  logic        aw_hs, w_hs, wr_now;

  assign axi.M_AXI_AWREADY = (aw_cnt >= aw_delay);
  assign axi.M_AXI_WREADY  = (w_cnt >= w_delay);
  assign axi.M_AXI_ARREADY = (ar_cnt >= ar_delay);
  assign axi.M_AXI_BVALID  = s_bvalid;
  assign axi.M_AXI_BRESP   = s_bresp;
  assign axi.M_AXI_RVALID  = s_rvalid;
  assign axi.M_AXI_RDATA   = s_rdata;
  assign axi.M_AXI_RRESP   = 2'b00;

  assign aw_hs  = axi.M_AXI_AWVALID & axi.M_AXI_AWREADY;
  assign w_hs   = axi.M_AXI_WVALID & axi.M_AXI_WREADY;
  assign wr_now = (aw_got | aw_hs) & (w_got | w_hs);
  assign wr_a   = aw_got ? aw_addr_q : axi.M_AXI_AWADDR;
  assign wr_d   = w_got ? w_data_q : axi.M_AXI_WDATA;

  always @(posedge ACLK) begin
    if (!ARESETN) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0;
      s_bvalid <= 1'b0; s_rvalid <= 1'b0; s_bresp <= 2'b00; s_rdata <= '0;
    end else begin
      if (aw_hs) aw_cnt <= 0; else if (axi.M_AXI_AWVALID) aw_cnt <= aw_cnt + 1;
      if (w_hs) w_cnt <= 0; else if (axi.M_AXI_WVALID) w_cnt <= w_cnt + 1;
      if (axi.M_AXI_ARVALID && axi.M_AXI_ARREADY) ar_cnt <= 0;
      else if (axi.M_AXI_ARVALID) ar_cnt <= ar_cnt + 1;
      if (aw_hs) begin aw_got <= 1'b1; aw_addr_q <= axi.M_AXI_AWADDR; end
      if (w_hs) begin w_got <= 1'b1; w_data_q <= axi.M_AXI_WDATA; end
      if (s_bvalid && axi.M_AXI_BREADY) s_bvalid <= 1'b0;
      if (wr_now) begin
        mem[wr_a[5:2]] <= wr_d;
        s_bvalid <= 1'b1;
        s_bresp  <= (int'(wr_a >> 2) == slverr_idx) ? 2'b10 : 2'b00;
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
      end
      if (axi.M_AXI_ARVALID && axi.M_AXI_ARREADY) begin
        s_rvalid <= 1'b1;
        s_rdata  <= mem[axi.M_AXI_ARADDR[5:2]] ^
                    ((int'(axi.M_AXI_ARADDR >> 2) == flip_idx) ? 32'h1 : 32'h0);
      end else if (s_rvalid && axi.M_AXI_RREADY) begin
        s_rvalid <= 1'b0;
      end
    end
  end

  // ---------------- checking helpers ----------------
  int n_cmp = 0, n_fail = 0;
  int awv_cyc, wv_cyc, aw_hs_n, w_hs_n, addr_bad, data_bad, lat;
  logic [31:0] cur_seed;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] s, input int n);
    return (n == 0) ? s : ((s << n) | (s >> (32 - n)));
  endfunction

  task automatic sample();
    if (axi.M_AXI_AWVALID === 1'b1) begin
      awv_cyc++;
      if (axi.M_AXI_AWADDR !== 32'(aw_hs_n * 4)) addr_bad++;
      if (axi.M_AXI_AWREADY) aw_hs_n++;
    end
    if (axi.M_AXI_WVALID === 1'b1) begin
      wv_cyc++;
      if (axi.M_AXI_WDATA !== rotl(cur_seed, w_hs_n)) data_bad++;
      if (axi.M_AXI_WREADY) w_hs_n++;
    end
  endtask

  // Launch a run and wait for done; lat is the cycle index of done with
  // the start cycle numbered 0.  A second start pulse may be injected at
  // cycle restart_at (0 = none); it must be ignored.
  task automatic run(input logic [31:0] s, input int restart_at, input int budget);
    bit seen;
    awv_cyc = 0; wv_cyc = 0; aw_hs_n = 0; w_hs_n = 0; addr_bad = 0; data_bad = 0;
    cur_seed = s; seed = s; lat = 0; seen = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    sample();
    for (int k = 1; k <= budget; k++) begin
      tick();
      start = (k == restart_at);
      sample();
      if (done === 1'b1) begin
        lat = k + 1;
        seen = 1;
        break;
      end
    end
    start = 1'b0;
    check("done_seen", seen, 1);
  endtask

  initial begin
    // ---- reset ----
    tick(); tick();
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err_count", err_count, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_awvalid", axi.M_AXI_AWVALID, 0);
    check("rst_wvalid", axi.M_AXI_WVALID, 0);
    check("rst_bready", axi.M_AXI_BREADY, 0);
    check("rst_arvalid", axi.M_AXI_ARVALID, 0);
    check("rst_rready", axi.M_AXI_RREADY, 0);
    check("rst_awaddr", axi.M_AXI_AWADDR, 0);
    check("rst_wdata", axi.M_AXI_WDATA, 0);
    ARESETN = 1'b1;
    tick();

    // ---- basic run, always-ready slave, stray start mid-run ----
    check("wstrb", axi.M_AXI_WSTRB, 4'hF);
    run(32'h0101FFFF, 5, 200);
    check("r1_latency", lat, 17);
    check("r1_pass", pass, 1);
    check("r1_err_count", err_count, 0);
    check("r1_resp_err", resp_err, 0);
    check("r1_mem0", mem[0], 32'h0101FFFF);
    check("r1_mem1", mem[1], 32'h0203FFFE);
    check("r1_mem2", mem[2], 32'h0407FFFC);
    check("r1_mem3", mem[3], 32'h080FFFF8);
    check("r1_awvalid_cycles", awv_cyc, 4);
    check("r1_wvalid_cycles", wv_cyc, 4);
    check("r1_addr_seq", addr_bad, 0);
    tick(); tick(); tick();
    check("r1_done_held", done, 1);
    check("r1_pass_held", pass, 1);

    // ---- read data corrupted on register 2 ----
    flip_idx = 2;
    run(32'h80000001, 0, 200);
    check("r2_latency", lat, 17);
    check("r2_err_count", err_count, 1);
    check("r2_pass", pass, 0);
    check("r2_resp_err", resp_err, 0);
    check("r2_mem3", mem[3], 32'h0000000C);
    flip_idx = -1;

    // ---- SLVERR write response on register 1 ----
    slverr_idx = 1;
    run(32'hA5A5_0F0F, 0, 200);
    check("r3_resp_err", resp_err, 1);
    check("r3_err_count", err_count, 1);
    check("r3_pass", pass, 0);
    check("r3_done", done, 1);
    slverr_idx = -1;

    // ---- AWREADY delayed 3 cycles, WREADY immediate ----
    aw_delay = 3;
    seed = 32'h1234_5678;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("r4_clr_done", done, 0);
    check("r4_clr_err_count", err_count, 0);
    check("r4_clr_resp_err", resp_err, 0);
    for (int k = 0; k < 300 && done !== 1'b1; k++) tick();
    run(32'h1234_5678, 0, 300);
    check("r4_awvalid_cycles", awv_cyc, 16);
    check("r4_wvalid_cycles", wv_cyc, 4);
    check("r4_awaddr_stable", addr_bad, 0);
    check("r4_wdata", data_bad, 0);
    check("r4_pass", pass, 1);
    check("r4_latency", lat, 29);

    // ---- reverse: WREADY delayed 3 cycles, AWREADY immediate ----
    aw_delay = 0;
    w_delay = 3;
    run(32'hDEAD_BEEF, 0, 300);
    check("r5_awvalid_cycles", awv_cyc, 4);
    check("r5_wvalid_cycles", wv_cyc, 16);
    check("r5_wdata_stable", data_bad, 0);
    check("r5_addr_seq", addr_bad, 0);
    check("r5_pass", pass, 1);
    check("r5_mem1", mem[1], 32'hBD5B_7DDF);
    w_delay = 0;

    // ---- reset during RDATA of register 1 ----
    begin
      bit hit;
      hit = 0;
      seed = 32'h0F0F_0F0F;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 40; k++) begin
        if (axi.M_AXI_RREADY === 1'b1 && axi.M_AXI_ARADDR === 32'h4) begin
          hit = 1;
          break;
        end
        tick();
      end
      check("r6_reached_rdata1", hit, 1);
      ARESETN = 1'b0;
      tick();
      check("r6_awvalid", axi.M_AXI_AWVALID, 0);
      check("r6_wvalid", axi.M_AXI_WVALID, 0);
      check("r6_bready", axi.M_AXI_BREADY, 0);
      check("r6_arvalid", axi.M_AXI_ARVALID, 0);
      check("r6_rready", axi.M_AXI_RREADY, 0);
      check("r6_done", done, 0);
      check("r6_err_count", err_count, 0);
      ARESETN = 1'b1;
      tick(); tick();
      check("r6_idle_awvalid", axi.M_AXI_AWVALID, 0);
      check("r6_idle_done", done, 0);
      run(32'h0101FFFF, 0, 200);
      check("r6_fresh_latency", lat, 17);
      check("r6_fresh_pass", pass, 1);
    end

`ifdef REGTEST_TIMEOUT_EN
    // ---- ARREADY stuck low ----
    ar_delay = 100000;
    run(32'h0000_00FF, 0, 1200);
    check("r7_timeout", timeout, 1);
    check("r7_done", done, 1);
    check("r7_pass", pass, 0);
    check("r7_arvalid", axi.M_AXI_ARVALID, 0);
    check("r7_latency", lat, 1027);
    ar_delay = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
